// File: rtl/video_pkg.sv
// Shared definitions for the video capture path.
// Holds the capture FSM encoding, the default 640x480 timing shared with the
// transmitter, the decimated output geometry and the RGB888 -> RGB332 packer.
package video_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2
   } fsm_e;

   // 640x480 @ 60 Hz timing, shared with the transmitter
   localparam int DEF_H_FRONT_PORCH = 16;
   localparam int DEF_H_SYNC_PULSE  = 96;
   localparam int DEF_H_BACK_PORCH  = 48;
   localparam int DEF_H_FRAME_WIDTH = 640;
   localparam int DEF_V_FRONT_PORCH = 10;
   localparam int DEF_V_SYNC_PULSE  = 2;
   localparam int DEF_V_BACK_PORCH  = 33;
   localparam int DEF_V_FRAME_WIDTH = 480;

   localparam int OUT_W          = DEF_H_FRAME_WIDTH / 2;
   localparam int OUT_H          = DEF_V_FRAME_WIDTH / 2;
   localparam int WORDS_PER_LINE = OUT_W / 4;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;

   function automatic logic [7:0] pack8(input logic [23:0] rgb);
      return {rgb[23:21], rgb[15:13], rgb[7:6]};
   endfunction

endpackage

// File: rtl/video_capture_if.sv
// Video BRAM write port (32-bit word, byte enables).
//   mem_en    : one-cycle write strobe per word
//   mem_we    : byte enables
//   mem_addr  : word address
//   mem_write : write data
// master = capture side, slave = BRAM side.
interface video_capture_if;
   import video_pkg::*;

   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_write;

   modport master (output mem_en, output mem_we, output mem_addr, output mem_write);
   modport slave  (input  mem_en, input  mem_we, input  mem_addr, input  mem_write);

endinterface

// File: rtl/video_capture_sync_tracker.sv
// Input stage and sync tracking for the capture path.
// Registers the stream, finds hsync/vsync edges, keeps the horizontal and
// vertical position counters and decodes which samples survive 2x decimation.
//   clk, rst          : pixel clock, synchronous active-high reset
//   red/green/blue    : pixel data
//   hsync, vsync      : sync inputs
//   vrel, vact        : vsync released / vsync asserted (combinational)
//   px_keep           : registered sample is a kept pixel
//   px_lane, px_data  : byte lane and RGB332 value of that sample
//   line_len          : cycles between the last two hsync releases
module sync_tracker
   import video_pkg::*;
#(
   parameter bit H_SYNC_ACTIVE = 1'b0,
   parameter bit V_SYNC_ACTIVE = 1'b0,
   parameter int H_BACK_PORCH  = DEF_H_BACK_PORCH,
   parameter int H_FRAME_WIDTH = DEF_H_FRAME_WIDTH,
   parameter int V_BACK_PORCH  = DEF_V_BACK_PORCH,
   parameter int V_FRAME_WIDTH = DEF_V_FRAME_WIDTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  red,
   input  logic [7:0]  green,
   input  logic [7:0]  blue,
   input  logic        hsync,
   input  logic        vsync,
   output logic        vrel,
   output logic        vact,
   output logic        px_keep,
   output logic [1:0]  px_lane,
   output logic [7:0]  px_data,
   output logic [15:0] line_len
);

   localparam logic [15:0] H_LO = 16'(H_BACK_PORCH);
   localparam logic [15:0] H_HI = 16'(H_BACK_PORCH + H_FRAME_WIDTH);
   localparam logic [15:0] V_LO = 16'(V_BACK_PORCH);
   localparam logic [15:0] V_HI = 16'(V_BACK_PORCH + V_FRAME_WIDTH);

   logic [23:0] s1_rgb;
   logic        s1_hs, s1_vs, s2_hs, s2_vs;
   logic [15:0] h_cnt, v_cnt, h_inc, h_nxt, v_nxt;
   logic        hrel, h_act, v_act;
   logic [2:0]  x_lo;
   logic        y_lo;

   assign hrel = (s1_hs != H_SYNC_ACTIVE) && (s2_hs == H_SYNC_ACTIVE);
   assign vrel = (s1_vs != V_SYNC_ACTIVE) && (s2_vs == V_SYNC_ACTIVE);
   assign vact = (s1_vs == V_SYNC_ACTIVE) && (s2_vs != V_SYNC_ACTIVE);

   // h_nxt/v_nxt are the position of the sample now sitting in stage 1
   assign h_inc = (h_cnt == 16'hFFFF) ? h_cnt : h_cnt + 16'd1;
   assign h_nxt = hrel ? 16'd0 : h_inc;

   always_comb begin
      v_nxt = v_cnt;
      if (vrel)
         v_nxt = 16'd0;
      else if (hrel && v_cnt != 16'hFFFF)
         v_nxt = v_cnt + 16'd1;
   end

   assign h_act = (h_nxt >= H_LO) && (h_nxt < H_HI);
   assign v_act = (v_nxt >= V_LO) && (v_nxt < V_HI);
   // only the low bits of x/y matter for decimation and lane select
   assign x_lo  = h_nxt[2:0] - H_LO[2:0];
   assign y_lo  = v_nxt[0] ^ V_LO[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_rgb   <= '0;
         s1_hs    <= ~H_SYNC_ACTIVE;
         s1_vs    <= ~V_SYNC_ACTIVE;
         s2_hs    <= ~H_SYNC_ACTIVE;
         s2_vs    <= ~V_SYNC_ACTIVE;
         h_cnt    <= '0;
         v_cnt    <= '0;
         line_len <= '0;
         px_keep  <= 1'b0;
         px_lane  <= '0;
         px_data  <= '0;
      end else begin
         s1_rgb   <= {red, green, blue};
         s1_hs    <= hsync;
         s1_vs    <= vsync;
         s2_hs    <= s1_hs;
         s2_vs    <= s1_vs;
         h_cnt    <= h_nxt;
         v_cnt    <= v_nxt;
         if (hrel)
            line_len <= h_inc;
         px_keep  <= h_act && v_act && !x_lo[0] && !y_lo;
         px_lane  <= x_lo[2:1];
         px_data  <= pack8(s1_rgb);
      end
   end

endmodule

// File: rtl/video_capture.sv
// VGA stream capture: decimates the active window 2x, packs four RGB332
// pixels per word and writes complete frames into the video BRAM.
//   clk, rst        : pixel clock, synchronous active-high reset
//   red/green/blue  : pixel data;  hsync, vsync : sync inputs
//   start           : arm one capture;  continuous : re-arm after each frame
//   base            : frame buffer word address, latched at frame start
//   mem             : BRAM write port (master)
//   busy, done, err : status;  line_len : measured line length
//
// state   | meaning
// IDLE    | no capture pending, waiting for start
// ARMED   | waiting for vsync release to begin a frame
// CAPTURE | writing the frame; done/err pulse is the last cycle here
module video_capture
   import video_pkg::*;
#(
   parameter bit H_SYNC_ACTIVE = 1'b0,
   parameter bit V_SYNC_ACTIVE = 1'b0,
   parameter int H_BACK_PORCH  = DEF_H_BACK_PORCH,
   parameter int H_FRAME_WIDTH = DEF_H_FRAME_WIDTH,
   parameter int V_BACK_PORCH  = DEF_V_BACK_PORCH,
   parameter int V_FRAME_WIDTH = DEF_V_FRAME_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        red,
   input  logic [7:0]        green,
   input  logic [7:0]        blue,
   input  logic              hsync,
   input  logic              vsync,
   input  logic              start,
   input  logic              continuous,
   input  logic [ADDR_W-1:0] base,
   video_capture_if.master   mem,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       line_len
);

   localparam int                FRAME_WORDS = (V_FRAME_WIDTH / 2) * (H_FRAME_WIDTH / 8);
   localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(FRAME_WORDS - 1);

   fsm_e              state_q, state_d;
   logic              vrel, vact, px_keep;
   logic [1:0]        px_lane;
   logic [7:0]        px_data;
   logic [7:0]        lane0, lane1, lane2;
   logic [ADDR_W-1:0] base_q, word_idx;
   logic              abort, word_fire;

   sync_tracker #(
      .H_SYNC_ACTIVE (H_SYNC_ACTIVE),
      .V_SYNC_ACTIVE (V_SYNC_ACTIVE),
      .H_BACK_PORCH  (H_BACK_PORCH),
      .H_FRAME_WIDTH (H_FRAME_WIDTH),
      .V_BACK_PORCH  (V_BACK_PORCH),
      .V_FRAME_WIDTH (V_FRAME_WIDTH)
   ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .red      (red),
      .green    (green),
      .blue     (blue),
      .hsync    (hsync),
      .vsync    (vsync),
      .vrel     (vrel),
      .vact     (vact),
      .px_keep  (px_keep),
      .px_lane  (px_lane),
      .px_data  (px_data),
      .line_len (line_len)
   );

   // once done/err is up the frame is closed: no abort and no more writes
   assign abort     = (state_q == CAPTURE) && vact && !done && !err;
   assign word_fire = (state_q == CAPTURE) && px_keep && (px_lane == 2'd3)
                      && !done && !err && !abort;
   assign busy      = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ARMED;
         ARMED:   if (vrel)  state_d = CAPTURE;
         CAPTURE: begin
            if (done)
               state_d = continuous ? ARMED : IDLE;
            else if (err)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         base_q        <= '0;
         word_idx      <= '0;
         lane0         <= '0;
         lane1         <= '0;
         lane2         <= '0;
         mem.mem_en    <= 1'b0;
         mem.mem_we    <= 4'h0;
         mem.mem_addr  <= '0;
         mem.mem_write <= '0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem.mem_en <= word_fire;
         mem.mem_we <= word_fire ? 4'hF : 4'h0;
         done       <= word_fire && (word_idx == LAST_IDX);
         err        <= abort;
         if (state_q == ARMED && vrel) begin
            base_q   <= base;
            word_idx <= '0;
         end
         if (state_q == CAPTURE && px_keep) begin
            case (px_lane)
               2'd0:    lane0 <= px_data;
               2'd1:    lane1 <= px_data;
               2'd2:    lane2 <= px_data;
               default: ;
            endcase
         end
         if (word_fire) begin
            mem.mem_addr  <= base_q + word_idx;
            mem.mem_write <= {px_data, lane2, lane1, lane0};
            word_idx      <= word_idx + 1'b1;
         end
      end
   end

endmodule
